// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch queue. The head is a register, so decode never sees a
// combinational path from the ROM. Flush only clears the count.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t tail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count stays put; with only one entry the new word becomes the head.
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, ROM address generation, push arbitration and
// the RUN/FAULT state machine in front of a two-entry output queue.
//   state | meaning
//   RUN   | fetching sequentially while enabled and in range
//   FAULT | out-of-range or misaligned fetch; waits for a redirect
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic         fault_next;
  logic         push, pop, flush;
  logic         in_range, room;
  logic [1:0]   count;
  fetch_entry_t head, din;

  assign pop      = out_valid && out_ready;
  assign in_range = ({2'b00, pc[31:2]} < ROM_SIZE);
  assign room     = (count != 2'd2) || pop;
  assign din      = '{pc: pc, instr: im_data};

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      fault <= fault_next;
    end
  end

  // Redirect outranks everything, including a fetch from the current PC.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    fault_next = fault;
    push       = 1'b0;
    flush      = 1'b0;
    if (redir_valid) begin
      flush   = 1'b1;
      pc_next = {redir_pc[31:2], 2'b00};
      if (redir_pc[1:0] != 2'b00) begin
        state_next = FAULT;
        fault_next = 1'b1;
      end else begin
        state_next = RUN;
        fault_next = 1'b0;
      end
    end else if (state == RUN && en) begin
      if (!in_range) begin
        state_next = FAULT;
        fault_next = 1'b1;
      end else if (room) begin
        push    = 1'b1;
        pc_next = pc + PC_STEP;
      end
    end
  end

  always_comb begin
    im_addr   = {2'b00, pc[31:2]};
    out_valid = (count != 2'd0);
    out_pc    = head.pc;
    out_instr = head.instr;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a queue-level reference model feeds a
// scoreboard that a monitor drains on every decode handshake.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned ROM_SIZE = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc = RESET_PC;
  logic        m_fault = 1'b0;
  logic        mon_on = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  // ROM word k holds the value k
  assign im_data = im_addr;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .ROM_SIZE(ROM_SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .im_addr     (im_addr),
    .im_data     (im_data),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .fault       (fault)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle of inputs, then advance the reference model across the
  // coming edge (the monitor has already retired any handshake by then).
  task automatic step(input logic r, input logic e, input logic rdy,
                      input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst_n = r; en = e; out_ready = rdy; redir_valid = rv; redir_pc = rpc;
    #2;
    if (!r) begin
      exp_q.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else if (rv) begin
      exp_q.delete();
      m_pc    = {rpc[31:2], 2'b00};
      m_fault = (rpc[1:0] != 2'b00);
    end else if (e && !m_fault) begin
      if ((m_pc >> 2) >= ROM_SIZE) m_fault = 1'b1;
      else if (exp_q.size() < 2) begin
        exp_q.push_back('{pc: m_pc, instr: m_pc >> 2});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic chk_reset();
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_im_addr", im_addr, RESET_PC >> 2);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_on) begin
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        chk("im_addr", im_addr, m_pc >> 2);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        if (out_valid && out_ready && rst_n) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out: got pc %h instr %h expected none", out_pc, out_instr);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", out_instr, e.instr);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] tgt;
    step(0, 0, 0, 0, 0);
    mon_on = 1'b1;
    chk_reset();
    // streaming from reset
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);
    // back-pressure then release
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
    // redirect with a full queue
    for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 32'h40);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
    // run off the end of the ROM, then recover
    step(1, 1, 1, 1, 32'hF0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 32'h0);
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 0);
    // misaligned redirect and recovery
    step(1, 1, 1, 1, 32'h22);
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 32'h24);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
    // reset with a full queue and fault set
    step(1, 1, 0, 1, 32'hF8);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk_reset();
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(0, 1, 0, 0, 0);
      end else if ($urandom_range(0, 9) == 0) begin
        tgt = {$urandom_range(0, 70), 2'b00};
        if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
        step(1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), 1, tgt);
      end else begin
        step(1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), 0, 0);
      end
    end
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the schoolRISCV core, directly upstream of the instruction ROM. Holds the program counter and drives the ROM word address. Captures the combinationally returned instruction word into a 2-entry output queue and hands `{pc, instr}` to decode over a valid/ready handshake. Accepts redirects from execute (branch/jump) and flags fetches outside the ROM or to misaligned targets.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_0000`: byte address loaded into PC at reset.
- `ROM_SIZE`, `64`: ROM depth in 32-bit words; word addresses `>= ROM_SIZE` are out of range.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  fetch enable; 0 freezes PC and pushes, draining continues.
- `im_addr`  out  32  ROM word address, `{2'b00, pc[31:2]}`.
- `im_data`  in  32  ROM read data, valid combinationally in the same cycle.
- `redir_valid`  in  1  redirect request (one-cycle pulse or held).
- `redir_pc`  in  32  redirect target byte address.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  decode accepts head this cycle.
- `out_instr`  out  32  head instruction word.
- `out_pc`  out  32  head instruction byte address.
- `fault`  out  1  fetch fault flag, sticky until a good redirect.

## Operation
- States: `RUN`, `FAULT`. Reset → `RUN`.
- Pop: `out_valid && out_ready`; head removed, next entry moves up.
- Push condition (`RUN` only): `en && !redir_valid && (count < 2 || pop) && pc[31:2] < ROM_SIZE`. Push writes `{pc, im_data}` at tail; `pc <= pc + 4` (32-bit wrap, no flag).
- Range check: in `RUN` with `en && !redir_valid` and `pc[31:2] >= ROM_SIZE` → no push, PC held, `fault <= 1`, state → `FAULT`.
- `FAULT`: no pushes; queue still drains via pop; PC held. Only a redirect leaves `FAULT`.
- Redirect (any state, highest priority): queue cleared (`count <= 0`), no push that cycle, `pc <= {redir_pc[31:2], 2'b00}`. A pop in the same cycle is still a completed transfer. If `redir_pc[1:0] != 0` → `fault <= 1`, state `FAULT`; else `fault <= 0`, state `RUN`.
- Simultaneous push and pop: allowed at count 1 (stays 1) and count 2 (stays 2).
- `out_valid = (count != 0)`; `out_instr`/`out_pc` come directly from the head register, no combinational path from `im_data`.

## Timing
- Reset (`rst_n == 0` at edge): `pc = RESET_PC`, `count = 0`, head/tail entries `= 0`, `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, `fault = 0`, state `RUN`. Reset mid-operation discards queue contents in that edge.
- `im_addr` is combinational from the PC register only.
- Fetch-to-decode latency: 1 cycle; instruction fetched in cycle N is at `out_*` in cycle N+1.
- Throughput: 1 instr/cycle with `out_ready` held high.
- Redirect in cycle N: `out_valid = 0` in N+1; first fetch from target in N+1, presented in N+2.
- With `out_ready = 0`, queue fills after 2 pushes; PC stops at the third address; no loss or duplication.

## Structure
- Package `fetch_pkg`: `fetch_state_e` (`RUN`, `FAULT`), `fetch_entry_t` struct `{logic [31:0] pc; logic [31:0] instr;}`, constant `PC_STEP = 4`.
- Sub-module `fetch_fifo`: 2-entry queue of `fetch_entry_t` with push/pop/flush, count, head output; synchronous active-low reset.
- Top holds PC register, state machine, range/alignment checks and push arbitration.

## Test plan
- Reset, `en = 1`, `out_ready = 1`, ROM word k = `k`: out sequence `(pc 0, instr 0), (4, 1), (8, 2)…` starting 1 cycle after reset release, one per cycle.
- `out_ready = 0` for 5 cycles: `out_valid = 1`, head stays `(0, 0)`, `im_addr` stops at 2; release → `(0,0),(4,1),(8,2)` in order, no gaps or repeats.
- Redirect to `0x40` while queue holds 2 entries: next cycle `out_valid = 0`, following cycle head `(0x40, word 16)`, `fault = 0`.
- Run off the end with `ROM_SIZE = 64`: after `pc = 0xFC` pushed, `fault = 1`, state `FAULT`, no further pushes, queue drains; redirect to `0x0` clears `fault`.
- Redirect to `0x22`: `fault = 1`, PC = `0x20`, no fetch; redirect to `0x24` → `fault = 0`, head `(0x24, word 9)`.
- Assert `rst_n = 0` with 2 queued entries and `fault = 1`: next cycle all outputs at reset values, `im_addr = RESET_PC >> 2`.
